bcd_to_bin: RTL and testbench

- Sequential BCD-to-binary converter; the consumer side of the team's 4-digit BCD counters.
- Captures a packed BCD word on a Start pulse and converts it one digit per clock, MSD first (acc = acc*10 + digit).
- Presents an unsigned binary result with a one-cycle Done strobe.
- Used ahead of binary comparators and arithmetic that take the BCD count value.

---
 rtl/bcd_to_bin_pkg.sv | 25 ++
 rtl/bcd_to_bin_digit_mac.sv | 35 +++
 rtl/bcd_to_bin.sv | 154 +++++++++++++++
 tb/tb_bcd_to_bin.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_pkg.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_pkg
//   Shared definitions for the sequential BCD-to-binary converter and the
//   digit multiply-accumulate helper.
//
//   Contents:
//     DIGITS_DEF / BIN_W_DEF : default word geometry (4 digits -> 14 bits)
//     state_t                : converter FSM encoding (IDLE, CONV, DONE)
//     BCD_MAX                : largest legal BCD digit value
// ---------------------------------------------------------------------------
package bcd_to_bin_pkg;

    localparam int DIGITS_DEF = 4;
    // 2^BIN_W must exceed 10^DIGITS - 1; 14 bits covers 9999.
    localparam int BIN_W_DEF  = 14;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : bcd_to_bin_pkg

// File: rtl/bcd_to_bin_digit_mac.sv
// ---------------------------------------------------------------------------
// bcd_digit_mac
//   Combinational decimal multiply-accumulate step: next = acc*10 + digit,
//   truncated to BIN_W bits. Also flags a digit that is not a legal BCD code.
//
//   Ports:
//     acc           in  BIN_W  running binary accumulator
//     digit         in  4      BCD digit to fold in
//     next          out BIN_W  acc*10 + digit (modulo 2^BIN_W)
//     digit_invalid out 1      digit > 9
// ---------------------------------------------------------------------------
module bcd_digit_mac
    import bcd_to_bin_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] next,
    output logic             digit_invalid
);

    // Four spare bits hold the full x10 product before truncation.
    logic [BIN_W+3:0] acc_ext;
    logic [BIN_W+3:0] digit_ext;

    assign acc_ext   = {4'b0000, acc};
    assign digit_ext = {{BIN_W{1'b0}}, digit};

    // x10 as x8 + x2: two shifts and an add, no multiplier.
    assign next = BIN_W'((acc_ext << 3) + (acc_ext << 1) + digit_ext);

    assign digit_invalid = (digit > BCD_MAX);

endmodule : bcd_digit_mac

// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
//   Sequential BCD-to-binary converter. A Start pulse in IDLE captures the
//   packed BCD word; one digit is folded in per clock, most significant digit
//   first (acc = acc*10 + digit). After DIGITS clocks the result is loaded
//   into Binary and a one-cycle Done strobe is raised.
//
//   Ports:
//     Clock   in  1         rising-edge clock
//     Resetn  in  1         asynchronous, active-low reset
//     Start   in  1         conversion request, sampled only in IDLE
//     BCD_in  in  4*DIGITS  packed BCD, most significant digit on top
//     Busy    out 1         conversion in progress
//     Done    out 1         one-cycle strobe; Binary/Error valid
//     Error   out 1         captured word held a digit > 9
//     Binary  out BIN_W     result (0 on error), held until next completion
// ---------------------------------------------------------------------------
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   BCD_in,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [BIN_W-1:0]      Binary
);

    localparam int               CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

    state_t              state;
    state_t              next_state;

    logic [4*DIGITS-1:0] shreg;
    logic [BIN_W-1:0]    acc;
    logic [CNT_W-1:0]    count;
    logic                err_flag;

    logic                accept;
    logic                last_digit;
    logic                start_invalid;
    logic [3:0]          top_digit;
    logic [BIN_W-1:0]    mac_next;
    logic                mac_invalid;

    // -----------------------------------------------------------------------
    // Control decodes
    // -----------------------------------------------------------------------
    assign accept     = (state == IDLE) && Start;
    assign last_digit = (state == CONV) && (count == LAST);
    assign top_digit  = shreg[4*DIGITS-1 -: 4];

    // Any illegal digit in the incoming word marks the whole conversion bad.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        start_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD_in[4*i +: 4] > BCD_MAX) begin
                start_invalid = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Digit multiply-accumulate
    // -----------------------------------------------------------------------
    bcd_digit_mac #(
        .BIN_W (BIN_W)
    ) u_mac (
        .acc           (acc),
        .digit         (top_digit),
        .next          (mac_next),
        .digit_invalid (mac_invalid)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start)      next_state = CONV;
            CONV:    if (last_digit) next_state = DONE;
            // DONE lasts exactly one cycle; Start is ignored here.
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            shreg    <= '0;
            acc      <= '0;
            count    <= '0;
            err_flag <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
            Binary   <= '0;
        end else begin
            // Done is a strobe: it only survives the one DONE cycle.
            Done <= 1'b0;

            if (accept) begin
                // Binary and Error keep the previous result until this
                // conversion completes.
                shreg    <= BCD_in;
                acc      <= '0;
                count    <= '0;
                err_flag <= start_invalid;
                Busy     <= 1'b1;
            end else if (state == CONV) begin
                acc      <= mac_next;
                shreg    <= shreg << 4;
                count    <= count + 1'b1;
                // The digit seen by the MAC was already checked at capture;
                // folding it in again keeps the flag honest on its own.
                err_flag <= err_flag | mac_invalid;

                if (last_digit) begin
                    // An invalid word still runs full latency, then reports 0.
                    Binary <= (err_flag || mac_invalid) ? '0 : mac_next;
                    Error  <= err_flag | mac_invalid;
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                end
            end
        end
    end

endmodule : bcd_to_bin

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin
//   Directed bench for bcd_to_bin. The driver pushes the hand-computed result
//   and the cycle at which Done must appear into a queue; an independent
//   monitor pops and compares every time the DUT raises Done.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin;

    localparam int DIGITS  = 4;
    localparam int BIN_W   = 14;
    localparam int LATENCY = DIGITS;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               cyc;
    } exp_t;

    logic                Clock;
    logic                Resetn;
    logic                Start;
    logic [4*DIGITS-1:0] BCD_in;
    logic                Busy;
    logic                Done;
    logic                Error;
    logic [BIN_W-1:0]    Binary;

    exp_t             sb_q[$];
    int               checks;
    int               errors;
    int               cyc;
    logic             prev_done;
    logic [BIN_W-1:0] last_bin;
    logic             last_err;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .BCD_in (BCD_in),
        .Busy   (Busy),
        .Done   (Done),
        .Error  (Error),
        .Binary (Binary)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Rising edges since time zero; read on the falling edge.
    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: compares every Done against the oldest expectation
    // -----------------------------------------------------------------------
    initial prev_done = 1'b0;
    always @(negedge Clock) begin
        if (Resetn && Done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("binary", 32'(Binary), 32'(e.bin));
                check("error",  32'(Error),  32'(e.err));
                check("done_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_done <= Done;
    end

    // -----------------------------------------------------------------------
    // Driver: issues one conversion from a falling edge, optionally keeps
    // Start high with changing words through CONV and DONE, and returns at
    // the falling edge just before the earliest legal next Start.
    // -----------------------------------------------------------------------
    task automatic issue(input logic [4*DIGITS-1:0] word,
                         input int exp_bin, input logic exp_err,
                         input bit spam);
        exp_t e;
        Start  = 1'b1;
        BCD_in = word;
        @(posedge Clock);              // accepting edge k
        @(negedge Clock);
        e.bin = BIN_W'(exp_bin);
        e.err = exp_err;
        e.cyc = cyc + LATENCY;
        sb_q.push_back(e);
        check("busy_after_start", 32'(Busy), 32'd1);
        check("binary_held_on_start", 32'(Binary), 32'(last_bin));
        check("error_held_on_start", 32'(Error), 32'(last_err));
        Start  = spam;
        BCD_in = word ^ 16'h1111;
        for (int i = 1; i < LATENCY; i++) begin
            @(negedge Clock);          // after edge k+i
            check("busy_during_conv", 32'(Busy), 32'd1);
            check("no_early_done", 32'(Done), 32'd0);
            BCD_in = word ^ (16'h1111 * (i + 1));
        end
        @(negedge Clock);              // after edge k+DIGITS: DONE cycle
        check("busy_clear_at_done", 32'(Busy), 32'd0);
        last_bin = BIN_W'(exp_bin);
        last_err = exp_err;
        BCD_in = word ^ 16'h5555;
        @(negedge Clock);              // after edge k+DIGITS+1: back in IDLE
        Start = 1'b0;
        check("done_cleared", 32'(Done), 32'd0);
        check("binary_held_idle", 32'(Binary), 32'(last_bin));
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        checks   = 0;
        errors   = 0;
        last_bin = '0;
        last_err = 1'b0;
        Resetn   = 1'b0;
        Start    = 1'b0;
        BCD_in   = '0;

        repeat (3) @(negedge Clock);
        check("reset_busy",   32'(Busy),   32'd0);
        check("reset_done",   32'(Done),   32'd0);
        check("reset_error",  32'(Error),  32'd0);
        check("reset_binary", 32'(Binary), 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);

        // Basic conversions; each follows the previous at the earliest edge.
        issue(16'h0000,    0, 1'b0, 1'b0);
        issue(16'h1234, 1234, 1'b0, 1'b0);
        issue(16'h9999, 9999, 1'b0, 1'b0);
        issue(16'h0001,    1, 1'b0, 1'b0);

        // Invalid digit: full latency, zero result, then recovery.
        issue(16'h12A4,    0, 1'b1, 1'b0);
        issue(16'h0042,   42, 1'b0, 1'b0);

        // Start held high with changing words through CONV and DONE.
        issue(16'h0305,  305, 1'b0, 1'b1);

        // Idle gap: Binary must hold.
        repeat (3) @(negedge Clock);
        check("binary_held_gap", 32'(Binary), 32'd305);

        // Reset after two digits of a conversion: no Done may follow.
        Start  = 1'b1;
        BCD_in = 16'h7777;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("midreset_busy",   32'(Busy),   32'd0);
        check("midreset_done",   32'(Done),   32'd0);
        check("midreset_error",  32'(Error),  32'd0);
        check("midreset_binary", 32'(Binary), 32'd0);
        repeat (2) @(negedge Clock);
        Resetn   = 1'b1;
        last_bin = '0;
        last_err = 1'b0;
        repeat (6) @(negedge Clock);
        check("no_done_after_reset", 32'(Binary), 32'd0);

        issue(16'h0500,  500, 1'b0, 1'b0);

        repeat (10) @(negedge Clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_bcd_to_bin
